// File: rtl/module_sample_scheduler_pkg.sv
// Shared widths, default period, FSM encoding and output conversion for the sample scheduler.
// Latency: none (definitions only). Backpressure: none.
// Conversion clamps to the 18-bit range when SAMPLE_SCHED_SATURATE_EN is defined, else wraps.
package module_sample_scheduler_pkg;

    localparam int SAMPLE_W          = 18;
    localparam int ACC_W             = 21;
    localparam int SAMPLE_PERIOD_DEF = 2080;
    localparam int PCNT_W            = 16;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        OUT  = 2'd3
    } sched_state_t;

    typedef struct packed {
        logic signed [ACC_W-1:0] l;
        logic signed [ACC_W-1:0] r;
    } acc_t;

    function automatic logic signed [ACC_W-1:0] widen(input logic signed [SAMPLE_W-1:0] s);
        return {{(ACC_W-SAMPLE_W){s[SAMPLE_W-1]}}, s};
    endfunction

    function automatic logic signed [SAMPLE_W-1:0] acc_to_sample(input logic signed [ACC_W-1:0] a);
`ifdef SAMPLE_SCHED_SATURATE_EN
        logic signed [ACC_W-1:0] sat_max;
        logic signed [ACC_W-1:0] sat_min;
        sat_max = ACC_W'((1 << (SAMPLE_W-1)) - 1);
        sat_min = ~sat_max;
        if (a > sat_max) begin
            return sat_max[SAMPLE_W-1:0];
        end else if (a < sat_min) begin
            return sat_min[SAMPLE_W-1:0];
        end else begin
            return a[SAMPLE_W-1:0];
        end
`else
        return a[SAMPLE_W-1:0];
`endif
    endfunction

endpackage

// File: rtl/module_sample_tick_gen.sv
// Free-running period counter; tick marks the last clock of each sample period.
// Latency: tick is a registered-count compare, high for one clock every SAMPLE_PERIOD clocks.
// Backpressure: none, the cadence never stalls.
module module_sample_tick_gen
    import module_sample_scheduler_pkg::*;
#(
    parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);

    logic [PCNT_W-1:0] pcnt;

    assign tick = (pcnt == PCNT_W'(SAMPLE_PERIOD - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            pcnt <= '0;
        end else if (tick) begin
            pcnt <= '0;
        end else begin
            pcnt <= pcnt + PCNT_W'(1);
        end
    end

endmodule

// File: rtl/module_sample_scheduler.sv
// Polls NVOICES voices once per sample period, sums them and strobes one stereo sample to the DAC.
// Latency: strobe 2*NVOICES+1 clocks after the tick with single-cycle voice replies; +1 per reply wait.
// Backpressure: slow voices stretch the frame; a late frame is cut at the next tick with overrun.
// Saturating output conversion is enabled by defining SAMPLE_SCHED_SATURATE_EN.
module module_sample_scheduler
    import module_sample_scheduler_pkg::*;
#(
    parameter int SAMPLE_PERIOD = SAMPLE_PERIOD_DEF,
    parameter int NVOICES       = 8,
    parameter int IDX_W         = 3
) (
    input  logic                       clk,
    input  logic                       reset,
    output logic                       voice_req,
    output logic [IDX_W-1:0]           voice_idx,
    input  logic                       voice_rdy,
    input  logic signed [SAMPLE_W-1:0] voice_l,
    input  logic signed [SAMPLE_W-1:0] voice_r,
    output logic                       sample_out_rdy,
    output logic signed [SAMPLE_W-1:0] sample_out_l,
    output logic signed [SAMPLE_W-1:0] sample_out_r,
    output logic                       overrun
);

    sched_state_t     state;
    sched_state_t     state_nxt;
    logic [IDX_W-1:0] idx;
    logic [IDX_W-1:0] idx_nxt;
    acc_t             acc;
    acc_t             acc_nxt;
    logic             pend;
    logic             tick;
    logic             frame_start;
    logic             load_out;
    logic             abort;
    logic             last_voice;

    module_sample_tick_gen #(
        .SAMPLE_PERIOD(SAMPLE_PERIOD)
    ) u_tick_gen (
        .clk  (clk),
        .reset(reset),
        .tick (tick)
    );

    assign last_voice = (idx == IDX_W'(NVOICES - 1));

    always_comb begin
        state_nxt   = state;
        idx_nxt     = idx;
        acc_nxt     = acc;
        frame_start = 1'b0;
        load_out    = 1'b0;
        abort       = 1'b0;
        case (state)
            IDLE: begin
                if (tick || pend) begin
                    state_nxt   = REQ;
                    idx_nxt     = '0;
                    acc_nxt     = '0;
                    frame_start = 1'b1;
                end
            end
            REQ: begin
                state_nxt = WAIT;
            end
            WAIT: begin
                // A reply landing together with a pending tick is still counted.
                if (voice_rdy) begin
                    acc_nxt.l = acc.l + widen(voice_l);
                    acc_nxt.r = acc.r + widen(voice_r);
                    if (last_voice) begin
                        state_nxt = OUT;
                        load_out  = 1'b1;
                    end else begin
                        state_nxt = REQ;
                        idx_nxt   = idx + IDX_W'(1);
                    end
                end else if (pend) begin
                    state_nxt = OUT;
                    load_out  = 1'b1;
                    abort     = 1'b1;
                end
            end
            OUT: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            idx   <= '0;
            acc   <= '0;
            pend  <= 1'b0;
        end else begin
            state <= state_nxt;
            idx   <= idx_nxt;
            acc   <= acc_nxt;
            // A tick coinciding with a pend-driven start re-arms for the next frame.
            if (frame_start) begin
                pend <= tick & pend;
            end else if (tick) begin
                pend <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sample_out_l <= '0;
            sample_out_r <= '0;
            overrun      <= 1'b0;
        end else begin
            overrun <= abort;
            if (load_out) begin
                sample_out_l <= acc_to_sample(acc_nxt.l);
                sample_out_r <= acc_to_sample(acc_nxt.r);
            end
        end
    end

    assign voice_req      = (state == REQ);
    assign voice_idx      = idx;
    assign sample_out_rdy = (state == OUT);

endmodule

// File: tb/tb_module_sample_scheduler.sv
// Directed bench for the sample scheduler: cadence, summing, conversion, overrun, stray replies, reset.
module tb_module_sample_scheduler;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               voice_req;
    logic [2:0]         voice_idx;
    logic               voice_rdy;
    logic signed [17:0] voice_l;
    logic signed [17:0] voice_r;
    logic               sample_out_rdy;
    logic signed [17:0] sample_out_l;
    logic signed [17:0] sample_out_r;
    logic               overrun;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    int dly [8];
    bit dead [8];
    int vl [8];
    int vr [8];

    logic               resp_rdy = 1'b0;
    logic signed [17:0] resp_l = '0;
    logic signed [17:0] resp_r = '0;
    logic               stray_rdy = 1'b0;
    logic signed [17:0] stray_l = '0;
    logic signed [17:0] stray_r = '0;
    bit                 r_act = 1'b0;
    int                 r_cnt = 0;
    int                 r_idx = 0;

    assign voice_rdy = resp_rdy | stray_rdy;
    assign voice_l   = stray_rdy ? stray_l : resp_l;
    assign voice_r   = stray_rdy ? stray_r : resp_r;

    module_sample_scheduler #(
        .SAMPLE_PERIOD(2080),
        .NVOICES      (8),
        .IDX_W        (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .voice_req     (voice_req),
        .voice_idx     (voice_idx),
        .voice_rdy     (voice_rdy),
        .voice_l       (voice_l),
        .voice_r       (voice_r),
        .sample_out_rdy(sample_out_rdy),
        .sample_out_l  (sample_out_l),
        .sample_out_r  (sample_out_r),
        .overrun       (overrun)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Voice model: replies dly[i] cycles after seeing its request; dead voices never reply.
    always @(negedge clk) begin
        resp_rdy = 1'b0;
        if (reset) begin
            r_act = 1'b0;
        end else begin
            if (r_act) begin
                if (r_cnt <= 1) begin
                    resp_rdy = 1'b1;
                    resp_l   = 18'(vl[r_idx]);
                    resp_r   = 18'(vr[r_idx]);
                    r_act    = 1'b0;
                end else begin
                    r_cnt = r_cnt - 1;
                end
            end
            if (voice_req === 1'b1 && !dead[voice_idx]) begin
                r_act = 1'b1;
                r_cnt = dly[voice_idx];
                r_idx = int'(voice_idx);
            end
        end
    end

    task automatic check(input string tag, input logic signed [31:0] obs, input logic signed [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic wait_strobe(input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (sample_out_rdy === 1'b1) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_req(input int want, input int budget, output int t);
        t = -1;
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (voice_req === 1'b1 && int'(voice_idx) == want) begin
                t = cyc;
                break;
            end
        end
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) @(negedge clk);
    endtask

    task automatic set_voices(input int l, input int r);
        for (int i = 0; i < 8; i++) begin
            vl[i] = l;
            vr[i] = r;
        end
    endtask

    task automatic check_zero_outputs(input string tag);
        check({tag, "_req"}, 32'(voice_req), 0);
        check({tag, "_idx"}, 32'(voice_idx), 0);
        check({tag, "_rdy"}, 32'(sample_out_rdy), 0);
        check({tag, "_l"}, $signed(sample_out_l), 0);
        check({tag, "_r"}, $signed(sample_out_r), 0);
        check({tag, "_ovr"}, 32'(overrun), 0);
    endtask

    task automatic check_strobe(input string tag, input int l, input int r, input int ovr);
        check({tag, "_l"}, $signed(sample_out_l), l);
        check({tag, "_r"}, $signed(sample_out_r), r);
        check({tag, "_ovr"}, 32'(overrun), ovr);
    endtask

    initial begin
        int k;
        int t;
        int s_prev;
        int s_cur;
        int sat_l;
        int sat_r;

        for (int i = 0; i < 8; i++) begin
            dly[i]  = 1;
            dead[i] = 1'b0;
        end
        set_voices(1000, -1000);

        // Reset values
        repeat (3) @(negedge clk);
        check_zero_outputs("reset");
        reset = 1'b0;
        k = cyc;

        // Steady state: first frame follows the first tick at k+2079
        wait_cyc(k + 2080);
        check("f0_req", 32'(voice_req), 1);
        check("f0_idx", 32'(voice_idx), 0);
        wait_cyc(k + 2094);
        check("f0_req7", 32'(voice_req), 1);
        check("f0_idx7", 32'(voice_idx), 7);
        wait_strobe(100, s_cur);
        check("s1_time", s_cur - k, 2096);
        check_strobe("s1", 8000, -8000, 0);
        s_prev = s_cur;
        wait_strobe(2200, s_cur);
        check("s2_spacing", s_cur - s_prev, 2080);
        check_strobe("s2", 8000, -8000, 0);
        s_prev = s_cur;

        // Full-scale voices: wrap or clamp on output conversion
        set_voices(131071, -131072);
`ifdef SAMPLE_SCHED_SATURATE_EN
        sat_l = 131071;
        sat_r = -131072;
`else
        sat_l = -8;
        sat_r = 0;
`endif
        wait_strobe(2200, s_cur);
        check("s3_spacing", s_cur - s_prev, 2080);
        check_strobe("s3", sat_l, sat_r, 0);
        s_prev = s_cur;
        set_voices(1000, -1000);

        // Stray replies in IDLE and in REQ are ignored
        repeat (3) @(negedge clk);
        stray_l   = 18'sd5000;
        stray_r   = 18'sd5000;
        stray_rdy = 1'b1;
        @(negedge clk);
        stray_rdy = 1'b0;
        wait_req(2, 2200, t);
        check("stray_req2_seen", 32'(t >= 0), 1);
        stray_rdy = 1'b1;
        @(negedge clk);
        stray_rdy = 1'b0;
        @(negedge clk);
        check("stray_next_req", 32'(voice_req), 1);
        check("stray_next_idx", 32'(voice_idx), 3);
        wait_strobe(100, s_cur);
        check("s4_spacing", s_cur - s_prev, 2080);
        check_strobe("s4", 8000, -8000, 0);
        s_prev = s_cur;

        // Overrun: voice 3 silent, frame cut at the next tick
        dead[3] = 1'b1;
        wait_strobe(4300, s_cur);
        check("s5_spacing", s_cur - s_prev, 4145);
        check_strobe("s5", 3000, -3000, 1);
        dead[3] = 1'b0;
        s_prev = s_cur;
        @(negedge clk);
        check("s5_ovr_after", 32'(overrun), 0);
        check("s5_rdy_after", 32'(sample_out_rdy), 0);
        @(negedge clk);
        check("s5_restart_req", 32'(voice_req), 1);
        check("s5_restart_idx", 32'(voice_idx), 0);
        wait_strobe(100, s_cur);
        check("s6_spacing", s_cur - s_prev, 18);
        check_strobe("s6", 8000, -8000, 0);
        s_prev = s_cur;
        wait_strobe(2200, s_cur);
        check("s7_spacing", s_cur - s_prev, 2077);
        check_strobe("s7", 8000, -8000, 0);
        s_prev = s_cur;

        // Voice 7 replies in the same cycle as the tick
        dly[7] = 2065;
        wait_strobe(4300, s_cur);
        check("s8_spacing", s_cur - s_prev, 4144);
        check_strobe("s8", 8000, -8000, 0);
        dly[7] = 1;
        s_prev = s_cur;
        @(negedge clk);
        check("s8_idle_req", 32'(voice_req), 0);
        @(negedge clk);
        check("s8_restart_req", 32'(voice_req), 1);
        check("s8_restart_idx", 32'(voice_idx), 0);
        wait_strobe(100, s_cur);
        check("s9_spacing", s_cur - s_prev, 18);
        check_strobe("s9", 8000, -8000, 0);

        // Reset while waiting on voice 4
        wait_req(4, 2200, t);
        check("rst_req4_seen", 32'(t >= 0), 1);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check_zero_outputs("midrst");
        reset = 1'b0;
        k = cyc;
        wait_strobe(2200, s_cur);
        check("s10_time", s_cur - k, 2096);
        check_strobe("s10", 8000, -8000, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
